axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//   Shares one AXI4 read channel (AR+R) between two masters: M0 = ICACHE line refill, M1 = LSU load.
//   Sits between the cache/LSU and the memory-side crossbar; one outstanding transaction total.
//   Routes AR of the granted master to the slave, then steers R beats back until the rlast handshake.
//   Flags malformed bursts, where the beat count disagrees with arlen.
// PARAMETERS
//   ADDR_W  32  address width of araddr on all ports
//   DATA_W  32  data width of rdata on all ports
// PORTS  (m{0,1}_ = one identical port per master; s_ = slave side)
//   clock          in   1       single clock, rising edge
//   reset          in   1       synchronous, active-high
//   m{0,1}_arvalid in   1       master read-address valid
//   m{0,1}_arready out  1       address accepted (owner only)
//   m{0,1}_araddr  in   ADDR_W  read address
//   m{0,1}_arlen   in   8       burst length-1
//   m{0,1}_arsize  in   3       beat size
//   m{0,1}_arburst in   2       burst type
//   m{0,1}_rvalid  out  1       routed read-data valid
//   m{0,1}_rready  in   1       master ready for data
//   m{0,1}_rdata   out  DATA_W  routed read data; 0 when not owner
//   m{0,1}_rresp   out  2       routed response
//   m{0,1}_rlast   out  1       routed last beat
//   s_arvalid/s_araddr/s_arlen/s_arsize/s_arburst  out       slave AR, muxed from owner
//   s_arready      in   1       slave AR accept
//   s_rvalid/s_rdata/s_rresp/s_rlast               in        slave R channel
//   s_rready       out  1       = owner's rready in DATA, else 0
//   grant          out  1       current/last owner index (0=M0, 1=M1)
//   busy           out  1       state != IDLE
//   protocol_err   out  1       sticky burst-length / AR-withdraw error
// BEHAVIOUR
//   Reset: state=IDLE, grant=0, last_grant=1, protocol_err=0.
//     Every valid/ready output=0, every data/addr output=0.
//   FSM IDLE -> AR -> DATA -> IDLE (2-bit register).
//   IDLE: if any m*_arvalid, pick the winner per policy (CONFIGURATION).
//     Register grant and go AR; this is 1 cycle arbitration latency. No outputs are asserted in IDLE.
//   AR: s_ar* = owner m_ar* (combinational mux).
//     owner arready = s_arready; the other master's arready = 0.
//     On s_arvalid & s_arready: latch expected = {1'b0,arlen}+1 (9-bit), clear beat_cnt (9-bit), go DATA.
//     If the owner drops arvalid before the handshake: protocol_err<=1, go IDLE.
//   DATA: owner rvalid/rdata/rresp/rlast = s_r*; s_rready = owner rready.
//     The non-owner sees rvalid=0, rdata=0. Each s_rvalid & s_rready increments beat_cnt.
//     Handshake with s_rlast: go IDLE. If beat_cnt+1 != expected, set protocol_err.
//     Handshake without rlast when beat_cnt+1 == expected: set protocol_err and stay in DATA until rlast.
//   rresp passes through unchanged; SLVERR/DECERR do not alter the FSM.
//   Non-owner requests are never dropped: its arvalid waits with arready=0 until it is granted.
//   Back-to-back: the next s_arvalid rises 2 cycles after the rlast handshake (IDLE cycle + AR cycle).
//   Reset mid-burst: state IDLE, all outputs return to reset values next cycle. The slave shares this reset.
//   grant holds its value in IDLE; last_grant updates on entry to AR.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined: on conflict, grant the master != last_grant.
//     A single requester always wins. Alternates M0,M1,M0,... under constant contention.
//   Undefined: fixed priority, M1 (LSU) always wins on conflict. last_grant is still maintained but unused.
// STRUCTURE
//   Package axi_arb_pkg: localparams ST_IDLE=2'b00, ST_AR=2'b01, ST_DATA=2'b10;
//     BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
//   Sub-module axi_beat_counter: latches expected on AR handshake, counts R handshakes, emits len_err pulse.
// TESTING
//   1 Release reset; M0 araddr=0x8000_0000 arlen=3, s_arready=1 -> s_arvalid high in cycle 2;
//     4 beats reach M0; m1_rvalid stays 0; busy falls after rlast.
//   2 M0 and M1 request in the same cycle, RR off -> M1 served fully first; m0_arready=0 until M0 AR state.
//   3 RR on, both request continuously with arlen=0 -> grant sequence 0,1,0,1.
//   4 s_arready held low for 5 cycles -> s_arvalid/s_araddr stable; owner arready high only in the handshake cycle.
//   5 arlen=3, slave asserts rlast on beat 2 -> protocol_err=1 (sticky), FSM IDLE; next burst completes normally.
//   6 reset pulsed during DATA beat 2 -> next cycle IDLE, all outputs 0, protocol_err=0.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared state encoding and AXI field constants for the two-master AXI4 read arbiter.
package axi_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_AR   = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    AR   = ST_AR,
    DATA = ST_DATA
  } state_e;

endpackage

// File: rtl/axi_beat_counter.sv
// Counts R handshakes of the burst in flight and pulses len_err when the rlast
// position disagrees with the burst length captured at the AR handshake.
module axi_beat_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       ar_hs,
  input  logic [7:0] arlen,
  input  logic       r_hs,
  input  logic       rlast,
  output logic       len_err
);

  logic [8:0] expected;
  logic [8:0] beat_cnt;
  logic [8:0] beat_nxt;

  assign beat_nxt = beat_cnt + 9'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      expected <= '0;
      beat_cnt <= '0;
    end else if (ar_hs) begin
      expected <= {1'b0, arlen} + 9'd1;
      beat_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= beat_nxt;
    end
  end

  // rlast too early/late, or the final counted beat arrives without rlast
  assign len_err = r_hs & (rlast ? (beat_nxt != expected) : (beat_nxt == expected));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (M0 = icache refill, M1 = LSU), one outstanding burst.
// Define ARB_ROUND_ROBIN_EN for round-robin on conflict; otherwise M1 has fixed priority.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  output logic              grant,
  output logic              busy,
  output logic              protocol_err
);

  state_e state;
  logic   last_grant;
  logic   winner;
  logic   in_ar, in_data;
  logic   ar_hs, r_hs, len_err;

  logic [1:0]             arvalid, rready, arready, rvalid, rlast, own;
  logic [1:0][ADDR_W-1:0] araddr;
  logic [1:0][7:0]        arlen;
  logic [1:0][2:0]        arsize;
  logic [1:0][1:0]        arburst, rresp;
  logic [1:0][DATA_W-1:0] rdata;

  assign arvalid = {m1_arvalid, m0_arvalid};
  assign rready  = {m1_rready,  m0_rready};
  assign araddr  = {m1_araddr,  m0_araddr};
  assign arlen   = {m1_arlen,   m0_arlen};
  assign arsize  = {m1_arsize,  m0_arsize};
  assign arburst = {m1_arburst, m0_arburst};

  assign in_ar   = (state == AR);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);
  assign own     = {grant, ~grant};

`ifdef ARB_ROUND_ROBIN_EN
  assign winner = (&arvalid) ? ~last_grant : arvalid[1];
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner = arvalid[1];
`endif

  // Slave AR is driven only while the owner's address is being offered
  assign s_arvalid = in_ar & arvalid[grant];
  assign s_araddr  = in_ar ? araddr[grant]  : '0;
  assign s_arlen   = in_ar ? arlen[grant]   : '0;
  assign s_arsize  = in_ar ? arsize[grant]  : '0;
  assign s_arburst = in_ar ? arburst[grant] : '0;
  assign s_rready  = in_data & rready[grant];

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  for (genvar i = 0; i < 2; i++) begin : g_m
    assign arready[i] = in_ar & own[i] & s_arready;
    assign rvalid[i]  = in_data & own[i] & s_rvalid;
    assign rdata[i]   = (in_data & own[i]) ? s_rdata : '0;
    assign rresp[i]   = (in_data & own[i]) ? s_rresp : '0;
    assign rlast[i]   = in_data & own[i] & s_rlast;
  end

  assign m0_arready = arready[0];
  assign m0_rvalid  = rvalid[0];
  assign m0_rdata   = rdata[0];
  assign m0_rresp   = rresp[0];
  assign m0_rlast   = rlast[0];
  assign m1_arready = arready[1];
  assign m1_rvalid  = rvalid[1];
  assign m1_rdata   = rdata[1];
  assign m1_rresp   = rresp[1];
  assign m1_rlast   = rlast[1];

  axi_beat_counter u_beat_cnt (
    .clock   (clock),
    .reset   (reset),
    .ar_hs   (ar_hs),
    .arlen   (s_arlen),
    .r_hs    (r_hs),
    .rlast   (s_rlast),
    .len_err (len_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      protocol_err <= 1'b0;
    end else begin
      if (len_err) protocol_err <= 1'b1;
      case (state)
        IDLE: if (|arvalid) begin
          grant      <= winner;
          last_grant <= winner;
          state      <= AR;
        end
        AR: begin
          // owner withdrew its address before the slave took it
          if (!arvalid[grant]) begin
            protocol_err <= 1'b1;
            state        <= IDLE;
          end else if (s_arready) begin
            state <= DATA;
          end
        end
        DATA: if (r_hs && s_rlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst, s_rresp;
  logic [DW-1:0] s_rdata;
  logic          grant, busy, protocol_err;

  logic [1:0]    pend, rrdy;
  logic [AW-1:0] a_addr [2];
  logic [7:0]    a_len  [2];
  int            a_nb   [2];
  int            a_wait [2];

  logic [1:0]    arrdy_o, rvld_o, rlast_o;
  logic [DW-1:0] rdata_o [2];
  logic [1:0]    rresp_o [2];
  assign arrdy_o    = {m1_arready, m0_arready};
  assign rvld_o     = {m1_rvalid, m0_rvalid};
  assign rlast_o    = {m1_rlast, m0_rlast};
  assign rdata_o[0] = m0_rdata;
  assign rdata_o[1] = m1_rdata;
  assign rresp_o[0] = m0_rresp;
  assign rresp_o[1] = m1_rresp;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(pend[0]), .m0_arready(m0_arready), .m0_araddr(a_addr[0]), .m0_arlen(a_len[0]),
    .m0_arsize(SIZE_4B), .m0_arburst(BURST_INCR), .m0_rvalid(m0_rvalid), .m0_rready(rrdy[0]),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(pend[1]), .m1_arready(m1_arready), .m1_araddr(a_addr[1]), .m1_arlen(a_len[1]),
    .m1_arsize(3'b011), .m1_arburst(2'b10), .m1_rvalid(m1_rvalid), .m1_rready(rrdy[1]),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  int npass = 0;
  int ntot  = 0;
  bit lg_m  = 1'b1;
  bit err_m = 1'b0;
  int rereq_pct = 0, max_len = 3, err_pct = 0;

  task automatic chk(input string tag, input bit ok);
    ntot++;
    if (ok) npass++;
    else $error("FAIL %s", tag);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic new_req(input int m, input logic [AW-1:0] addr, input int len, input int nb, input int wt);
    pend[m]   = 1'b1;
    a_addr[m] = addr;
    a_len[m]  = 8'(len);
    a_nb[m]   = nb;
    a_wait[m] = wt;
  endtask

  task automatic rnd_req(input int m);
    int len, nb;
    len = $urandom_range(0, max_len);
    nb  = ($urandom_range(1, 100) <= err_pct) ? $urandom_range(1, len + 2) : len + 1;
    new_req(m, $urandom, len, nb, $urandom_range(0, 2));
  endtask

  function automatic bit model_pick();
    if (pend == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~lg_m;
`else
      return 1'b1;
`endif
    end
    return pend[1];
  endfunction

  task automatic serve();
    bit w, hs;
    int len, nb;
    w = model_pick();
    #1;
    chk("idle_busy", busy === 1'b0);
    chk("idle_s_arvalid", s_arvalid === 1'b0);
    chk("idle_arready", arrdy_o === 2'b00);
    cyc();
    lg_m = w;
    #1;
    chk("ar_grant", grant === w);
    chk("ar_busy", busy === 1'b1);
    chk("ar_s_arvalid", s_arvalid === 1'b1);
    chk("ar_s_arlen", s_arlen === a_len[w]);
    chk("ar_s_arsize", s_arsize === (w ? 3'b011 : SIZE_4B));
    chk("ar_s_arburst", s_arburst === (w ? 2'b10 : BURST_INCR));
    for (int i = 0; i < a_wait[w]; i++) begin
      chk("ar_wait_arready", arrdy_o === 2'b00);
      chk("ar_wait_addr", s_araddr === a_addr[w]);
      cyc();
      #1;
    end
    s_arready = 1'b1;
    #1;
    chk("ar_hs_addr", s_araddr === a_addr[w]);
    chk("ar_hs_arready", arrdy_o === (w ? 2'b10 : 2'b01));
    cyc();
    s_arready = 1'b0;
    pend[w] = 1'b0;
    len = int'(a_len[w]);
    nb  = a_nb[w];
    for (int m = 0; m < 2; m++)
      if (!pend[m] && $urandom_range(1, 100) <= rereq_pct) rnd_req(m);
    for (int b = 0; b < nb; b++) begin
      hs = 1'b0;
      while (!hs) begin
        s_rvalid = ($urandom_range(0, 3) != 0);
        s_rdata  = $urandom;
        s_rresp  = 2'($urandom);
        s_rlast  = (b == nb - 1);
        rrdy[w]  = ($urandom_range(0, 3) != 0);
        rrdy[~w] = 1'($urandom);
        #1;
        chk("d_rvalid", rvld_o[w] === s_rvalid);
        chk("d_rdata", rdata_o[w] === s_rdata);
        chk("d_rresp", rresp_o[w] === s_rresp);
        chk("d_rlast", rlast_o[w] === s_rlast);
        chk("d_other_rvalid", rvld_o[~w] === 1'b0);
        chk("d_other_rdata", rdata_o[~w] === 32'h0);
        chk("d_s_rready", s_rready === rrdy[w]);
        chk("d_arready", arrdy_o === 2'b00);
        hs = s_rvalid & rrdy[w];
        cyc();
      end
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    rrdy     = 2'b00;
    if (nb != len + 1) err_m = 1'b1;
    #1;
    chk("end_busy", busy === 1'b0);
    chk("end_protocol_err", protocol_err === err_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pend = 2'b00; rrdy = 2'b00;
    for (int m = 0; m < 2; m++) new_req(m, '0, 0, 1, 0);
    pend = 2'b00;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = RESP_OKAY; s_rlast = 1'b1;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_grant", grant === 1'b0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_err", protocol_err === 1'b0);
    chk("rst_s_arvalid", s_arvalid === 1'b0);
    chk("rst_s_araddr", s_araddr === 32'h0);
    chk("rst_s_arlen", s_arlen === 8'h0);
    chk("rst_s_rready", s_rready === 1'b0);
    chk("rst_arready", arrdy_o === 2'b00);
    chk("rst_rvalid", rvld_o === 2'b00);
    chk("rst_rlast", rlast_o === 2'b00);
    chk("rst_m0_rdata", m0_rdata === 32'h0);
    chk("rst_m1_rdata", m1_rdata === 32'h0);
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;

    new_req(0, 32'h8000_0000, 3, 4, 0);
    serve();
    new_req(0, 32'h0000_1000, 1, 2, 0);
    new_req(1, 32'h0000_2000, 2, 3, 1);
    serve();
    serve();
    max_len = 0; rereq_pct = 100;
    rnd_req(0); rnd_req(1);
    for (int i = 0; i < 4; i++) serve();
    rereq_pct = 0;
    while (pend != 2'b00) serve();
    max_len = 3;
    new_req(1, 32'h4000_0040, 2, 3, 5);
    serve();
    new_req(0, 32'h0000_3000, 3, 2, 0);
    serve();
    new_req(0, 32'h0000_4000, 3, 4, 1);
    serve();

    new_req(0, 32'h0000_5000, 3, 4, 0);
    cyc();
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0; pend = 2'b00;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; rrdy = 2'b01;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; pend = 2'b01; s_arready = 1'b1;
    #1;
    chk("mid_rst_busy", busy === 1'b0);
    chk("mid_rst_grant", grant === 1'b0);
    chk("mid_rst_err", protocol_err === 1'b0);
    chk("mid_rst_s_arvalid", s_arvalid === 1'b0);
    chk("mid_rst_s_rready", s_rready === 1'b0);
    chk("mid_rst_rvalid", rvld_o === 2'b00);
    chk("mid_rst_m0_rdata", m0_rdata === 32'h0);
    chk("mid_rst_arready", arrdy_o === 2'b00);
    pend = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0; rrdy = 2'b00;
    lg_m = 1'b1; err_m = 1'b0;

    new_req(1, 32'h0000_6000, 0, 1, 0);
    lg_m = model_pick();
    cyc();
    #1;
    chk("wd_grant", grant === 1'b1);
    chk("wd_s_arvalid", s_arvalid === 1'b1);
    pend[1] = 1'b0;
    #1;
    chk("wd_drop_s_arvalid", s_arvalid === 1'b0);
    cyc();
    #1;
    err_m = 1'b1;
    chk("wd_err", protocol_err === err_m);
    chk("wd_busy", busy === 1'b0);

    err_pct = 15; rereq_pct = 50;
    for (int i = 0; i < 40; i++) begin
      if (pend == 2'b00) begin
        int mask;
        mask = $urandom_range(1, 3);
        for (int m = 0; m < 2; m++) if (mask[m]) rnd_req(m);
      end
      serve();
    end
    rereq_pct = 0;
    while (pend != 2'b00) serve();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
